// File: rtl/state_reg.sv
// Controller state register: samples the next-state vector on each rising clock edge.
// Illegal encodings either fall back to RESET_STATE or hold the current state.
module state_reg #(
  parameter int unsigned             WIDTH        = 3,
  parameter logic [WIDTH-1:0]        RESET_STATE  = '0,
  parameter logic [(1<<WIDTH)-1:0]   LEGAL_MASK   = '1,
  parameter bit                      ILLEGAL_HOLD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] state_in,
  output logic [WIDTH-1:0] state_out
);

  localparam int unsigned NUM_CODES = 1 << WIDTH;

  logic [NUM_CODES-1:0] code_hit;
  logic                 in_legal;
  logic [WIDTH-1:0]     state_next;
  logic [WIDTH-1:0]     cur_state_reg;

  // One-hot match of state_in against every legal encoding; X/Z inputs never match.
  for (genvar gi = 0; gi < NUM_CODES; gi++) begin : g_code
    assign code_hit[gi] = LEGAL_MASK[gi] && (state_in == WIDTH'(gi));
  end

  always_comb begin
    in_legal   = (|code_hit) && !$isunknown(state_in);
    state_next = RESET_STATE;
    if (in_legal) begin
      state_next = state_in;
    end else if (ILLEGAL_HOLD) begin
      state_next = cur_state_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state_reg <= RESET_STATE;
    end else begin
      cur_state_reg <= state_next;
    end
  end

  assign state_out = cur_state_reg;

endmodule

// File: tb/tb_state_reg.sv
// Self-checking bench for state_reg: directed scenarios plus randomized traffic,
// compared against a mask/policy reference model for three parameter sets.
`timescale 1ns/100ps
module tb_state_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_in;
  logic [2:0] out_def, out_rst, out_hold;
  logic [2:0] exp_def, exp_rst, exp_hold;
  int         n_checks = 0;
  int         n_fail   = 0;

  localparam logic [7:0] MASK_7F = 8'h7F;

  always #1 clk = ~clk;

  state_reg u_def (
    .clk(clk), .reset(reset), .state_in(state_in), .state_out(out_def)
  );
  state_reg #(.LEGAL_MASK(MASK_7F), .ILLEGAL_HOLD(1'b0)) u_rst (
    .clk(clk), .reset(reset), .state_in(state_in), .state_out(out_rst)
  );
  state_reg #(.LEGAL_MASK(MASK_7F), .ILLEGAL_HOLD(1'b1)) u_hold (
    .clk(clk), .reset(reset), .state_in(state_in), .state_out(out_hold)
  );

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d at t=%0t", tag, got, $time);
    end
  endtask

  // Reference: a legal value is taken, an illegal one resets to 0 or is ignored.
  function automatic logic [2:0] model_next(input logic [2:0] cur, input logic [2:0] v,
                                            input logic [7:0] mask, input bit hold);
    if (mask[v]) return v;
    return hold ? cur : 3'd0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".def"},  out_def,  exp_def);
    check({tag, ".rst"},  out_rst,  exp_rst);
    check({tag, ".hold"}, out_hold, exp_hold);
  endtask

  task automatic models_reset();
    exp_def = 3'd0; exp_rst = 3'd0; exp_hold = 3'd0;
  endtask

  // Called at a falling edge: drive v, let one rising edge pass, check 0.5 later,
  // then return at the following falling edge.
  task automatic cycle(input logic [2:0] v, input string tag);
    state_in = v;
    @(posedge clk);
    exp_def  = model_next(exp_def,  v, 8'hFF,   1'b0);
    exp_rst  = model_next(exp_rst,  v, MASK_7F, 1'b0);
    exp_hold = model_next(exp_hold, v, MASK_7F, 1'b1);
    #0.5;
    check_all(tag);
    @(negedge clk);
  endtask

  // Async reset pulse starting between edges, spanning n rising edges.
  task automatic reset_pulse(input logic [2:0] v, input int n, input string tag);
    #0.3;
    reset    = 1'b1;
    state_in = v;
    models_reset();
    #0.2;
    check_all({tag, ".imm"});
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #0.5;
      check_all({tag, ".held"});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    state_in = 3'd0;
    models_reset();

    // Power-up
    #0.5;
    check_all("pwr.t0");
    @(negedge clk);   // t=2
    check_all("pwr.t2");
    reset = 1'b0;
    cycle(3'd0, "pwr.e1");
    cycle(3'd0, "pwr.e2");

    // Load, and stable between edges
    cycle(3'd1, "load");
    #0.5;
    check_all("load.mid");
    @(negedge clk);

    // Async reset mid-operation, then load at first edge after release
    reset_pulse(3'd5, 2, "arst");
    cycle(3'd5, "arst.rel");

    // Non-sequential jumps, each held several cycles
    for (int i = 0; i < 3; i++) cycle(3'd6, "jump6a");
    for (int i = 0; i < 3; i++) cycle(3'd2, "jump2");
    for (int i = 0; i < 3; i++) cycle(3'd6, "jump6b");

    // Illegal encoding policy
    cycle(3'd2, "ill.pre");
    cycle(3'd7, "ill.seven");
    cycle(3'd3, "ill.rec");

    // Sampling: glitch on state_in between edges is ignored
    state_in = 3'd4;
    #0.3;
    state_in = 3'd3;
    #0.3;
    check_all("samp.mid");
    cycle(3'd3, "samp.edge");

    // Randomized traffic with occasional async resets and between-edge glitches
    for (int n = 0; n < 300; n++) begin
      logic [2:0] v;
      v = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) begin
        reset_pulse(v, $urandom_range(0, 2), "rnd.rst");
      end else if ($urandom_range(0, 9) == 0) begin
        state_in = 3'($urandom_range(0, 7));
        #0.4;
        cycle(v, "rnd.glitch");
      end else begin
        cycle(v, "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, required completion before t=20000");
    $fatal(1, "timeout");
  end

endmodule
